// File: rtl/da_sop_param.sv
// -----------------------------------------------------------------------------
// da_sop_param
// Bit-serial distributed-arithmetic sum-of-products engine.
//   y = sum_k C[k] * x[k]   (N signed inputs, N signed constant coefficients)
// The 2^N-entry LUT is built at elaboration time from COEFF. One input bit
// plane is consumed per cycle, LSB first, so a result takes B cycles.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  x_in valid
//   in_ready  block idle and able to accept
//   x_in      packed signed inputs, x[k] = x_in[k*B +: B]
//   y_valid   one-cycle strobe, y updated
//   y         signed result, held until the next result
//   lut       current LUT output (test observation)
//
// Optional feature macro: DA_SOP_SAT_EN
//   defined     : narrowing output conversion saturates to the Y_W range
//   not defined : narrowing output conversion wraps (keeps the low Y_W bits)
// -----------------------------------------------------------------------------
module da_sop_param #(
    parameter int               N     = 3,
    parameter int               B     = 4,
    parameter int               C_W   = 3,
    parameter logic [N*C_W-1:0] COEFF = {3'sd1, 3'sd3, 3'sd2},
    parameter int               Y_W   = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N*B-1:0]                  x_in,
    output logic                            y_valid,
    output logic signed [Y_W-1:0]           y,
    output logic signed [C_W+$clog2(N)-1:0] lut
);

    localparam int L_W   = C_W + $clog2(N);
    localparam int ACC_W = B + L_W;
    localparam int CNT_W = $clog2(B);
    localparam int LUT_N = 2 ** N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Coefficient k, sign-extended to the LUT width.
    function automatic logic signed [L_W-1:0] coeff_ext(input int k);
        logic signed [C_W-1:0] c;
        c = COEFF[k*C_W +: C_W];
        return L_W'(c);
    endfunction

    // Entry i holds the sum of C[k] over every set bit k of i.
    function automatic logic [LUT_N*L_W-1:0] build_lut();
        logic [LUT_N*L_W-1:0]  tbl;
        logic signed [L_W-1:0] acc;
        tbl = '0;
        for (int i = 0; i < LUT_N; i++) begin
            acc = '0;
            for (int k = 0; k < N; k++) begin
                if (i[k]) begin
                    acc = acc + coeff_ext(k);
                end
            end
            tbl[i*L_W +: L_W] = acc;
        end
        return tbl;
    endfunction

    localparam logic [LUT_N*L_W-1:0] LUT_TBL = build_lut();

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [N-1:0][B-1:0]     x_r;
    logic signed [ACC_W-1:0] p_r;
    logic signed [Y_W-1:0]   y_r;
    logic                    y_valid_r;

    logic [N-1:0]            idx_s;
    logic signed [L_W-1:0]   lut_s;
    logic signed [ACC_W-1:0] lut_w_s;
    logic signed [ACC_W-1:0] p_add_s;
    logic signed [ACC_W-1:0] r_s;
    logic signed [Y_W-1:0]   y_conv_s;
    logic                    load_s;
    logic                    last_s;

    // LUT address: current LSB of every input shift register.
    always_comb begin
        idx_s = '0;
        for (int k = 0; k < N; k++) begin
            idx_s[k] = x_r[k][0];
        end
    end

    // LUT read and the two accumulator updates (normal bit / sign bit).
    always_comb begin
        lut_s   = LUT_TBL[int'(idx_s)*L_W +: L_W];
        lut_w_s = ACC_W'(lut_s) <<< (B - 1);
        p_add_s = (p_r >>> 1'b1) + lut_w_s;
        r_s     = (p_r >>> 1'b1) - lut_w_s;
    end

    // Output conversion from accumulator width to Y_W.
    generate
        if (Y_W >= ACC_W) begin : g_ext
            always_comb y_conv_s = Y_W'(r_s);
        end else begin : g_narrow
`ifdef DA_SOP_SAT_EN
            localparam logic signed [ACC_W-1:0] Y_MAX =
                {{(ACC_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] Y_MIN =
                {{(ACC_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};
            // Clamp to the representable output range.
            always_comb begin
                if (r_s > Y_MAX) begin
                    y_conv_s = Y_MAX[Y_W-1:0];
                end else if (r_s < Y_MIN) begin
                    y_conv_s = Y_MIN[Y_W-1:0];
                end else begin
                    y_conv_s = r_s[Y_W-1:0];
                end
            end
`else
            // Two's-complement wrap: keep the low Y_W bits.
            always_comb y_conv_s = r_s[Y_W-1:0];
`endif
        end
    endgenerate

    // FSM next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: input shift registers, accumulator, bit counter, result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r       <= '0;
            p_r       <= '0;
            cnt_r     <= '0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= 1'b0;
            if (load_s) begin
                x_r   <= x_in;
                p_r   <= '0;
                cnt_r <= '0;
            end else if (state_r == ST_RUN) begin
                for (int k = 0; k < N; k++) begin
                    x_r[k] <= {1'b0, x_r[k][B-1:1]};
                end
                if (last_s) begin
                    // Sign-bit plane carries negative weight.
                    y_r       <= y_conv_s;
                    y_valid_r <= 1'b1;
                    cnt_r     <= '0;
                end else begin
                    p_r   <= p_add_s;
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
            end else begin
                x_r <= x_r;
            end
        end
    end

    assign in_ready = (state_r == ST_IDLE);
    assign lut      = lut_s;
    assign y        = y_r;
    assign y_valid  = y_valid_r;

endmodule
